ee354_2048_move_ctrl: RTL

Front-end command generator for the ee354_2048 game FSM. It takes the four raw pushbuttons, then synchronises, debounces and prioritises them. It issues exactly one single-cycle up/down/left/right pulse per physical press. A pulse is only issued while the game FSM reports q_Wait, so a move is never dropped or doubled while the FSM is processing a previous one.

---
 rtl/ee354_2048_move_ctrl_if.sv | 34 +++
 rtl/ee354_2048_move_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ee354_2048_move_ctrl_if.sv
// ee354_2048_move_ctrl_if
// Groups the pushbutton inputs, the game-FSM ready flag and the move-pulse
// outputs of the move controller into one bundle.
//   master : drives BtnU/BtnD/BtnL/BtnR/q_Wait, observes the move outputs
//   slave  : the move controller itself
// Signals:
//   BtnU, BtnD, BtnL, BtnR : raw asynchronous buttons, active-high
//   q_Wait                 : game FSM idle and ready for a move
//   up, down, left, right  : single-cycle move pulses
//   busy                   : controller not in IDLE
//   last_dir               : last issued move, 0=U 1=D 2=L 3=R
interface ee354_2048_move_ctrl_if;
  logic       BtnU;
  logic       BtnD;
  logic       BtnL;
  logic       BtnR;
  logic       q_Wait;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       busy;
  logic [1:0] last_dir;

  modport master (
    output BtnU, BtnD, BtnL, BtnR, q_Wait,
    input  up, down, left, right, busy, last_dir
  );

  modport slave (
    input  BtnU, BtnD, BtnL, BtnR, q_Wait,
    output up, down, left, right, busy, last_dir
  );
endinterface

// File: rtl/ee354_2048_move_ctrl.sv
// ee354_2048_move_ctrl
// Turns the four raw pushbuttons into single-cycle up/down/left/right
// commands for the 2048 game FSM: 2-FF synchroniser, press debounce,
// fixed priority U > D > L > R, pulse issued only while q_Wait is high,
// then release debounce so a held button cannot issue a second move.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-low
//   mv    : ee354_2048_move_ctrl_if.slave (buttons, q_Wait, move outputs)
// Optional feature macro: AUTO_REPEAT_EN -- when defined, holding the
// issued button for REPEAT_CYCLES re-issues the same move periodically.
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | no button seen; waiting for any synchronised press
// PRESS_DEB   | captured dir must stay high DEBOUNCE_CYCLES cycles
// ISSUE       | move pending; pulse on first cycle with q_Wait high
// RELEASE_DEB | all buttons must stay low DEBOUNCE_CYCLES cycles
module ee354_2048_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 64
) (
  input logic                   Clk,
  input logic                   Reset,
  ee354_2048_move_ctrl_if.slave mv
);

  if (((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) ||
      ((64'd1 << CNT_W) <= 64'(REPEAT_CYCLES))) begin : g_cnt_w_check
    $error("CNT_W too narrow for DEBOUNCE_CYCLES / REPEAT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DEB, ISSUE, RELEASE_DEB} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [3:0]       sync1, sync2;
  logic             bU, bD, bL, bR;
  logic [3:0]       btn;
  logic [1:0]       dir, dir_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       pulse_q, pulse_n;
  logic [1:0]       last_dir_q, last_dir_n;
  logic             busy_q;
  logic             dir_held;

`ifdef AUTO_REPEAT_EN
  // The repeat pulse appears one cycle after re-entering ISSUE, so the
  // jump happens one count early to keep pulses exactly REPEAT_CYCLES apart.
  localparam logic [CNT_W-1:0] REP_TRIG = CNT_W'(REPEAT_CYCLES - 2);
  logic [CNT_W-1:0] hold, hold_n;
`endif

  // Bit index equals the last_dir code: 0=U, 1=D, 2=L, 3=R.
  assign bU       = sync2[0];
  assign bD       = sync2[1];
  assign bL       = sync2[2];
  assign bR       = sync2[3];
  assign btn      = {bR, bL, bD, bU};
  assign dir_held = btn[dir];
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync1      <= '0;
      sync2      <= '0;
      state      <= IDLE;
      dir        <= '0;
      cnt        <= '0;
      pulse_q    <= '0;
      last_dir_q <= '0;
      busy_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
      hold       <= '0;
`endif
    end else begin
      sync1      <= {mv.BtnR, mv.BtnL, mv.BtnD, mv.BtnU};
      sync2      <= sync1;
      state      <= state_n;
      dir        <= dir_n;
      cnt        <= cnt_n;
      pulse_q    <= pulse_n;
      last_dir_q <= last_dir_n;
      busy_q     <= (state_n != IDLE);
`ifdef AUTO_REPEAT_EN
      hold       <= hold_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    dir_n      = dir;
    cnt_n      = cnt;
    pulse_n    = '0;
    last_dir_n = last_dir_q;
`ifdef AUTO_REPEAT_EN
    hold_n     = hold;
`endif
    case (state)
      IDLE: begin
        if (|btn) begin
          state_n = PRESS_DEB;
          cnt_n   = '0;
          if (bU)      dir_n = 2'd0;
          else if (bD) dir_n = 2'd1;
          else if (bL) dir_n = 2'd2;
          else         dir_n = 2'd3;
        end
      end
      PRESS_DEB: begin
        if (!dir_held) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = ISSUE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ISSUE: begin
        if (mv.q_Wait) begin
          pulse_n[dir] = 1'b1;
          last_dir_n   = dir;
          state_n      = RELEASE_DEB;
          cnt_n        = '0;
`ifdef AUTO_REPEAT_EN
          hold_n       = '0;
`endif
        end
      end
      RELEASE_DEB: begin
        if (|btn) begin
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
`ifdef AUTO_REPEAT_EN
        if (!dir_held) begin
          hold_n = '0;
        end else if (hold == REP_TRIG) begin
          state_n = ISSUE;
          cnt_n   = '0;
          hold_n  = '0;
        end else begin
          hold_n = (hold == CNT_MAX) ? hold : hold + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign mv.up       = pulse_q[0];
  assign mv.down     = pulse_q[1];
  assign mv.left     = pulse_q[2];
  assign mv.right    = pulse_q[3];
  assign mv.busy     = busy_q;
  assign mv.last_dir = last_dir_q;

endmodule
